// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte producers share one UART transmitter.
// It grants one requester at a time, strobes the byte out, and then tracks the UART busy handshake.
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_busy,
  output logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_send,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active,
  output logic [15:0]                   tx_count,
  output logic                          err_timeout
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick_id;
  logic              pick_found;
  logic [CNT_W-1:0]  wait_cnt;

  // Search starts one past the previous winner so every pending requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found && req_valid[ID_W'((int'(last_grant) + k) % NUM_REQ)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tx_send    = 1'b0;
    req_ready  = '0;
    active     = (state != IDLE);
    case (state)
      IDLE: begin
        if (pick_found && !tx_busy) begin
          next_state = SEND;
        end
      end
      SEND: begin
        tx_send    = 1'b1;
        req_ready  = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        next_state = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) begin
          next_state = WAIT_DONE;
        end else if (wait_cnt == WAIT_LIMIT) begin
          next_state = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: captured byte, grant bookkeeping, start-timeout counter and statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_data     <= '0;
      grant_id    <= '0;
      last_grant  <= LAST_ID;
      wait_cnt    <= '0;
      tx_count    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && pick_found && !tx_busy) begin
        tx_data  <= req_data[int'(pick_id)*DATA_BITS +: DATA_BITS];
        grant_id <= pick_id;
      end
      if (state == SEND) begin
        last_grant <= grant_id;
        wait_cnt   <= '0;
      end
      if (state == WAIT_START && !tx_busy) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt == WAIT_LIMIT) begin
          err_timeout <= 1'b1;
        end
      end
      if (state == WAIT_DONE && !tx_busy) begin
        tx_count <= tx_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a vector table, directed corner sequences,
// and a randomized run scored against a transaction-level round-robin model.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int DATA_BITS     = 8;
  localparam int START_TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic [1:0]  grant_id;
  logic        active;
  logic [15:0] tx_count;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [1:0]  exp_grant;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[10];

  always #5 clock = ~clock;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_BITS(DATA_BITS),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_busy(tx_busy),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .grant_id(grant_id),
    .active(active),
    .tx_count(tx_count),
    .err_timeout(err_timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid = v.valid;
    req_data  = v.data;
  endtask

  task automatic applyReset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Returns at the negedge where tx_send is high, counting negedges waited.
  task automatic waitSend(input string name, output int cycles);
    cycles = 0;
    while (!tx_send && cycles < 40) begin
      @(negedge clock);
      cycles++;
    end
    if (!tx_send) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: no tx_send after %0d cycles, expected one", name, cycles);
    end
  endtask

  // Called at the SEND-cycle negedge; plays the UART side of one completed byte.
  task automatic finishTransfer(input logic [3:0] keep_mask, input int hold);
    @(negedge clock);
    checkOutput("ready_pulse_len", {27'd0, tx_send, req_ready}, 32'd0);
    req_valid = req_valid & keep_mask;
    tx_busy   = 1'b1;
    repeat (hold) @(negedge clock);
    tx_busy = 1'b0;
    @(negedge clock);
  endtask

  function automatic int rrPick(input int last, input logic [3:0] v);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int cycles;
    int exp_id;
    int m_last;
    int m_count;
    logic m_err;
    int since_send;
    int rphase;
    int rd;
    int rh;
    logic [3:0] drop_mask;

    vecs[0] = '{4'b0100, 32'h115A2233, 2'd2, 8'h5A};
    vecs[1] = '{4'b1111, 32'hD3C3B3A3, 2'd3, 8'hD3};
    vecs[2] = '{4'b1111, 32'hD4C4B4A4, 2'd0, 8'hA4};
    vecs[3] = '{4'b0110, 32'hD5C5B5A5, 2'd1, 8'hB5};
    vecs[4] = '{4'b0110, 32'hD6C6B6A6, 2'd2, 8'hC6};
    vecs[5] = '{4'b0110, 32'hD7C7B7A7, 2'd1, 8'hB7};
    vecs[6] = '{4'b1001, 32'hD8C8B8A8, 2'd3, 8'hD8};
    vecs[7] = '{4'b0001, 32'h000000E1, 2'd0, 8'hE1};
    vecs[8] = '{4'b0001, 32'h000000E2, 2'd0, 8'hE2};
    vecs[9] = '{4'b1010, 32'hF0EEF1EE, 2'd1, 8'hF1};

    // Reset values while reset is held.
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_busy   = 1'b0;
    @(negedge clock);
    checkOutput("rst_tx_send", {31'd0, tx_send}, 32'd0);
    checkOutput("rst_req_ready", {28'd0, req_ready}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_grant_id", {30'd0, grant_id}, 32'd0);
    checkOutput("rst_tx_count", {16'd0, tx_count}, 32'd0);
    checkOutput("rst_err", {31'd0, err_timeout}, 32'd0);
    checkOutput("rst_active", {31'd0, active}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Vector table: one full transfer per entry, round-robin pointer carried across entries.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      waitSend("tbl_send", cycles);
      checkOutput("tbl_latency", cycles, 32'd1);
      checkOutput("tbl_grant", {30'd0, grant_id}, {30'd0, vecs[i].exp_grant});
      checkOutput("tbl_data", {24'd0, tx_data}, {24'd0, vecs[i].exp_data});
      checkOutput("tbl_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << vecs[i].exp_grant});
      checkOutput("tbl_active", {31'd0, active}, 32'd1);
      finishTransfer(4'b0000, 3);
      checkOutput("tbl_count", {16'd0, tx_count}, i + 1);
    end

    // All four requesters held valid: strict rotation.
    applyReset();
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      waitSend("rr_send", cycles);
      checkOutput("rr_grant", {30'd0, grant_id}, k % 4);
      checkOutput("rr_data", {24'd0, tx_data}, (k % 4) + 1 + 16 * ((k % 4) + 1));
      finishTransfer(4'b1111, 2);
    end
    checkOutput("rr_count", {16'd0, tx_count}, 32'd5);
    req_valid = '0;
    @(negedge clock);

    // tx_busy never rises: timeout, sticky error, then the same requester is granted again.
    applyReset();
    req_valid = 4'b0010;
    req_data  = 32'h00007700;
    waitSend("to_send", cycles);
    checkOutput("to_grant", {30'd0, grant_id}, 32'd1);
    for (int c = 1; c <= START_TIMEOUT; c++) begin
      @(negedge clock);
      checkOutput("to_wait_active", {31'd0, active}, 32'd1);
    end
    checkOutput("to_err_early", {31'd0, err_timeout}, 32'd0);
    @(negedge clock);
    checkOutput("to_idle", {31'd0, active}, 32'd0);
    checkOutput("to_err", {31'd0, err_timeout}, 32'd1);
    checkOutput("to_count", {16'd0, tx_count}, 32'd0);
    @(negedge clock);
    checkOutput("to_regrant_send", {31'd0, tx_send}, 32'd1);
    checkOutput("to_regrant_id", {30'd0, grant_id}, 32'd1);
    finishTransfer(4'b0000, 2);
    checkOutput("to_count_after", {16'd0, tx_count}, 32'd1);
    checkOutput("to_err_sticky", {31'd0, err_timeout}, 32'd1);

    // External busy blocks any grant until it falls.
    applyReset();
    tx_busy   = 1'b1;
    req_valid = 4'b0001;
    req_data  = 32'h000000C3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checkOutput("blk_no_send", {27'd0, tx_send, req_ready}, 32'd0);
    end
    tx_busy = 1'b0;
    @(negedge clock);
    checkOutput("blk_send", {31'd0, tx_send}, 32'd1);
    checkOutput("blk_data", {24'd0, tx_data}, 32'hC3);
    finishTransfer(4'b0000, 2);

    // Reset in the middle of WAIT_DONE.
    applyReset();
    req_valid = 4'b0010;
    req_data  = 32'h00008100;
    waitSend("mid_send1", cycles);
    finishTransfer(4'b0000, 2);
    req_valid = 4'b0100;
    req_data  = 32'h00820000;
    waitSend("mid_send2", cycles);
    @(negedge clock);
    req_valid = '0;
    tx_busy   = 1'b1;
    @(negedge clock);
    checkOutput("mid_pre_active", {31'd0, active}, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_send", {27'd0, tx_send, req_ready}, 32'd0);
    checkOutput("mid_rst_data", {24'd0, tx_data}, 32'd0);
    checkOutput("mid_rst_grant", {30'd0, grant_id}, 32'd0);
    checkOutput("mid_rst_count", {16'd0, tx_count}, 32'd0);
    checkOutput("mid_rst_active", {31'd0, active}, 32'd0);
    @(negedge clock);
    reset     = 1'b0;
    req_valid = 4'b1010;
    req_data  = 32'h93009100;
    repeat (2) begin
      @(negedge clock);
      checkOutput("mid_no_ready", {27'd0, tx_send, req_ready}, 32'd0);
    end
    tx_busy = 1'b0;
    waitSend("mid_send3", cycles);
    checkOutput("mid_grant_low", {30'd0, grant_id}, 32'd1);
    checkOutput("mid_data_low", {24'd0, tx_data}, 32'h91);
    finishTransfer(4'b0000, 2);

    // Counter wrap from 0xFFFF.
    applyReset();
    req_valid = 4'b0001;
    req_data  = 32'h0000005C;
    waitSend("wrap_send", cycles);
    @(negedge clock);
    req_valid = '0;
    tx_busy   = 1'b1;
    @(negedge clock);
    force dut.tx_count = 16'hFFFF;
    @(negedge clock);
    release dut.tx_count;
    tx_busy = 1'b0;
    @(negedge clock);
    checkOutput("wrap_count", {16'd0, tx_count}, 32'd0);
    checkOutput("wrap_idle", {31'd0, active}, 32'd0);

    // Randomized traffic against a transaction-level model.
    applyReset();
    m_last     = NUM_REQ - 1;
    m_count    = 0;
    m_err      = 1'b0;
    since_send = 0;
    rphase     = 0;
    rd         = 0;
    rh         = 0;
    drop_mask  = '0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge clock);
      exp_id = -1;
      if (tx_send) begin
        exp_id = rrPick(m_last, req_valid);
        if (exp_id < 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL rand_spurious_send: tx_send with req_valid=0x%0h, expected no send", req_valid);
        end else begin
          checkOutput("rand_grant", {30'd0, grant_id}, exp_id);
          checkOutput("rand_data", {24'd0, tx_data}, (req_data >> (8 * exp_id)) & 32'hFF);
          checkOutput("rand_ready", {28'd0, req_ready}, 32'd1 << exp_id);
          checkOutput("rand_count", {16'd0, tx_count}, m_count);
          checkOutput("rand_err", {31'd0, err_timeout}, {31'd0, m_err});
          m_last = exp_id;
        end
        since_send = 0;
        if ($urandom_range(0, 7) == 0) begin
          m_err  = 1'b1;
          rphase = 0;
        end else begin
          rphase = 1;
          rd     = $urandom_range(0, START_TIMEOUT - 1);
          rh     = $urandom_range(1, 4);
        end
      end else begin
        checkOutput("rand_idle_ready", {28'd0, req_ready}, 32'd0);
        since_send++;
      end
      if (rphase == 1) begin
        if (rd == 0) begin
          tx_busy = 1'b1;
          rphase  = 2;
        end else begin
          rd--;
        end
      end else if (rphase == 2) begin
        if (rh == 0) begin
          tx_busy = 1'b0;
          rphase  = 0;
          m_count++;
        end else begin
          rh--;
        end
      end
      req_valid = req_valid & ~drop_mask;
      drop_mask = (exp_id >= 0) ? (4'b0001 << exp_id) : 4'b0000;
      if (cyc < 1500) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
            req_data[8*i +: 8] = 8'($urandom);
            req_valid[i]       = 1'b1;
          end
        end
      end
      if (since_send > 40 && req_valid != 4'b0000) begin
        checks++;
        failures++;
        $display("[TB] FAIL rand_stall: %0d cycles without tx_send, expected a grant", since_send);
        break;
      end
    end
    checkOutput("rand_final_count", {16'd0, tx_count}, m_count);
    checkOutput("rand_final_err", {31'd0, err_timeout}, {31'd0, m_err});
    checkOutput("rand_final_active", {31'd0, active}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the UART transmitter, range 2..8.
REQ-002 Parameter DATA_BITS, default 8: byte width, equal to the uart DATA_BITS.
REQ-003 Parameter START_TIMEOUT, default 4: cycles allowed in WAIT_START for tx_busy to rise, range 1..255.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  requester i holds a byte pending; held high until accepted.
REQ-007 req_data  input  NUM_REQ*DATA_BITS  byte of requester i at bits [i*DATA_BITS +: DATA_BITS]; held stable while req_valid[i]=1.
REQ-008 req_ready  output  NUM_REQ  one-hot acceptance pulse; requester i's byte is consumed on the edge where req_valid[i] and req_ready[i] are both 1.
REQ-009 tx_busy  input  1  uart transmitter busy.
REQ-010 tx_data  output  DATA_BITS  byte to the uart; registered.
REQ-011 tx_send  output  1  one-cycle send strobe to the uart.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester most recently granted.
REQ-013 active  output  1  high whenever the FSM is not in IDLE.
REQ-014 tx_count  output  16  total bytes completed; wraps 0xFFFF -> 0x0000.
REQ-015 err_timeout  output  1  sticky flag, set when tx_busy fails to rise after a send.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, WAIT_START and WAIT_DONE, encoded internally.
REQ-017 IDLE -> SEND SHALL occur on the edge where any req_valid bit is 1 and tx_busy=0; the FSM SHALL NOT grant while tx_busy=1.
REQ-018 Grant selection SHALL be round-robin: search begins at index (last_grant+1) mod NUM_REQ and picks the first requester with req_valid=1.
REQ-019 On the IDLE -> SEND edge, the block SHALL load tx_data with the granted requester's req_data slice and load grant_id with its index.
REQ-020 In SEND (exactly one cycle), tx_send=1 and req_ready[grant_id]=1, with all other req_ready bits 0; SEND -> WAIT_START is unconditional.
REQ-021 The latency from req_valid sampled high in IDLE to tx_send high SHALL be one cycle.
REQ-022 The last_grant pointer SHALL update to grant_id on the SEND -> WAIT_START edge.
REQ-023 WAIT_START -> WAIT_DONE SHALL occur on the first edge with tx_busy=1.
REQ-024 If tx_busy stays 0 for START_TIMEOUT consecutive cycles in WAIT_START, the FSM SHALL go to IDLE, set err_timeout and leave tx_count unchanged.
REQ-025 WAIT_DONE -> IDLE SHALL occur on the first edge with tx_busy=0, and tx_count SHALL increment by 1 (mod 2^16) on that edge.
REQ-026 tx_send and req_ready SHALL be 0 in every state other than SEND.
REQ-027 tx_data SHALL hold its value outside the IDLE -> SEND edge.
REQ-028 If req_valid deasserts while the FSM is in SEND, the byte SHALL still be sent; the protocol violation is the requester's responsibility.
REQ-029 A requester that keeps req_valid high receives at most one grant per round while others are pending; with a single requester pending, back-to-back grants SHALL be permitted with one IDLE cycle between bytes.
REQ-030 err_timeout SHALL clear only on reset.

Reset
REQ-031 While reset=1, asynchronously: state=IDLE, tx_send=0, req_ready=0, tx_data=0, grant_id=0, last_grant=NUM_REQ-1 (requester 0 first in priority), tx_count=0, err_timeout=0, active=0.
REQ-032 A reset asserted mid-transfer SHALL abandon the byte; no req_ready pulse is produced after reset deasserts until a new grant.

Verification
REQ-033 Single request: reset, then req_valid=4'b0100 with data 0x5A, tx_busy model rising 1 cycle after send and held 10 cycles -> tx_send one cycle after valid, tx_data=0x5A, req_ready=4'b0100 for one cycle, grant_id=2, tx_count=1.
REQ-034 Round-robin: all four valid continuously after reset -> grant order 0,1,2,3,0, with tx_count=5 after five transfers.
REQ-035 Timeout: tx_busy tied 0, req_valid[1]=1 -> FSM returns to IDLE START_TIMEOUT cycles after WAIT_START entry, err_timeout=1, tx_count=0, then requester 1 is re-granted.
REQ-036 Busy blocking: tx_busy=1 externally while req_valid=4'b0001 -> no tx_send and no req_ready until tx_busy falls, then grant on the next edge.
REQ-037 Reset mid-WAIT_DONE: assert reset during an active transfer -> all outputs at their reset values immediately (asynchronously), and the next grant goes to the lowest-index valid requester.
REQ-038 Wrap: preload 0xFFFF transfers (or force tx_count), complete one more transfer -> tx_count=0x0000.
